// File: rtl/adder_sum_stage.sv
// Final prefix-adder stage: forms sum and flags from group G/P, then buffers
// results in a 2-entry queue so the consumer's ready never reaches back upstream.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

module adder_sum_carry (
  input  logic g,
  input  logic p,
  input  logic cin,
  output logic c
);
  assign c = g | (p & cin);
endmodule

module adder_sum_stage #(
  parameter int W = `LEN_DATA + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] generate_in,
  input  logic [W-1:0] propogate_in,
  input  logic [W-1:0] half_sum_in,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_out,
  output logic [3:0]   flags_out
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [3:0]   flags;
    logic [W-1:0] sum;
  } entry_t;

  logic [W:0]   c;
  logic [W-1:0] sum;
  entry_t       new_entry;

  // Group G/P already span [i:0], so every carry is one level from carry_in.
  assign c[0] = carry_in;
  for (genvar i = 0; i < W; i++) begin : g_carry
    adder_sum_carry u_carry (
      .g   (generate_in[i]),
      .p   (propogate_in[i]),
      .cin (carry_in),
      .c   (c[i+1])
    );
  end

  assign sum             = half_sum_in ^ c[W-1:0];
  assign new_entry.sum   = sum;
  assign new_entry.flags = {sum[W-1], ~|sum, c[W] ^ c[W-1], c[W]};

  state_t state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  logic   in_ready_q;
  logic   push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign sum_out   = head_q.sum;
  assign flags_out = head_q.flags;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = new_entry;
      end
      ONE: case ({push, pop})
        2'b10: begin state_d = FULL; tail_d = new_entry; end
        2'b01: state_d = EMPTY;
        2'b11: head_d = new_entry;
        default: ;
      endcase
      FULL: if (pop) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is flopped from the next count so out_ready has no path to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != FULL);
    end
  end
endmodule

// File: doc/adder_sum_stage.md
# adder_sum_stage

Final, registered stage of the pipelined parallel-prefix adder. It takes the group generate/propagate vectors from the last prefix stage, plus the per-bit half-sum and carry-in, and forms the sum and the flags (carry, overflow, zero, negative). Results are buffered in a 2-entry output queue with a valid/ready handshake, so the ALU result mux can stall without a combinational ready path back into the prefix tree.

## Interface
- `W`, default `` `LEN_DATA``+1: datapath width; bit vectors are `[W-1:0]`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: stage can accept a beat this cycle.
- `generate_in` in W: group generate, bit i = G[i:0].
- `propogate_in` in W: group propagate, bit i = P[i:0].
- `half_sum_in` in W: per-bit a^b.
- `carry_in` in 1: adder carry-in (1 for subtract).
- `out_valid` out 1: result present at head of queue.
- `out_ready` in 1: consumer accepts the head.
- `sum_out` out W: head sum.
- `flags_out` out 4: {negative, zero, overflow, carry} of the head.

## Operation
- Carries: c[0] = carry_in; c[i] = generate_in[i-1] | (propogate_in[i-1] & carry_in) for 1 ≤ i ≤ W.
- sum = half_sum_in ^ c[W-1:0].
- carry = c[W].
- overflow = c[W] ^ c[W-1].
- zero = (sum == 0).
- negative = sum[W-1].
- All flags are computed combinationally from the input beat and stored with the sum.
- Queue: two entries (head, tail) and a count in {EMPTY=0, ONE=1, FULL=2}.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != FULL). It is a registered decode of count and has no combinational path from out_ready.
- out_valid = (count != EMPTY). sum_out/flags_out always show the head entry.

Transitions:
- EMPTY: push → ONE, data to head.
- ONE, push only → FULL, data to tail.
- ONE, pop only → EMPTY.
- ONE, push and pop together → ONE, new data to head.
- FULL, pop → ONE, tail moves to head. Push cannot occur because in_ready=0.
- No push and no pop: hold all state.

## Timing
- Latency: a beat accepted at edge k is on sum_out/flags_out with out_valid=1 after edge k, provided the queue was empty or emptied by a simultaneous pop. Otherwise it appears after the older entries are popped.
- Throughput: one beat per cycle while out_ready=1.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Reset (asynchronous assert, synchronous-safe deassert): count=EMPTY, out_valid=0, in_ready=1, sum_out=0, flags_out=4'b0000, both entries cleared.
- Reset mid-operation discards all buffered beats immediately, with no further out_valid.
- in_valid while in_ready=0 is ignored. The upstream holds its data; this stage does not latch it.
- out_valid with out_ready=0 holds sum_out/flags_out stable until popped.

## Test plan
- W=32, a=0xFFFFFFFF, b=1: half_sum=0xFFFFFFFE, generate_in=0xFFFFFFFF, propogate_in=0, carry_in=0 → sum 0x00000000, flags {0,1,0,1}, out_valid one cycle after accept.
- Signed overflow, a=0x7FFFFFFF, b=1: half_sum=0x7FFFFFFE, generate_in=0x7FFFFFFF, propogate_in=0, carry_in=0 → sum 0x80000000, flags {1,0,1,0}.
- Subtract 5-5 (a=5, b=~5, carry_in=1): half_sum=0xFFFFFFFF, generate_in=0, propogate_in=0xFFFFFFFF → sum 0, flags {0,1,0,1}.
- Backpressure: out_ready=0, push 3 beats on consecutive cycles → first two accepted, in_ready=0 on the third; raise out_ready → beats emerge in order with no loss.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with distinct operands → 8 results on consecutive cycles, in_ready stays 1, count stays ONE.
- Reset while FULL: assert rst_n=0 → out_valid=0, in_ready=1, sum_out=0 at once; after release the next beat behaves as from EMPTY.
